// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// Module      : mem_stage
// Description : Pipeline MEM stage; a two-state FSM issues data-memory accesses
//               with a bounded wait and fills the MEM/WB register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] adder_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] writedata_in,
   input  logic        zero_in,
   input  logic        branch_in,
   input  logic        memtoreg_in,
   input  logic        memwrite_in,
   input  logic        regwrite_in,
   input  logic        addermuxselect_in,
   input  logic [4:0]  rd_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        pc_src_out,
   output logic [31:0] branch_target_out,
   output logic        stall_out,
   output logic        mem_err_out,
   output logic [31:0] readdata_out,
   output logic [31:0] alu_result_out,
   output logic [4:0]  rd_out,
   output logic        memtoreg_out,
   output logic        regwrite_out,
   output logic        valid_out
);

   localparam logic [7:0] c_timeout_last = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [4:0]  r_rd;
   logic        r_memtoreg;
   logic        r_memwrite;
   logic        r_regwrite;
   logic [7:0]  r_cnt;
   logic        r_err;

   logic        w_idle;
   logic        w_mem_op;
   logic        w_timeout;

   assign w_idle    = (r_state == IDLE);
   assign w_mem_op  = memtoreg_in | memwrite_in;
   assign w_timeout = (r_state == WAIT) && !mem_ack && (r_cnt == c_timeout_last);

   // Reset forces IDLE asynchronously, so the request drops without a clock.
   assign mem_req   = ~w_idle;
   assign mem_we    = ~w_idle & r_memwrite;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

   // Input-derived outputs are gated so every output reads 0 under reset.
   assign stall_out         = reset & (w_idle ? w_mem_op : 1'b1);
   assign pc_src_out        = reset & w_idle & branch_in & zero_in;
   assign branch_target_out = reset ? (addermuxselect_in ? alu_result_in : adder_in) : 32'd0;
   assign mem_err_out       = r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_mem_op) begin
               w_next_state = WAIT;
            end
         end
         WAIT: begin
            if (mem_ack || w_timeout) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr         <= 32'd0;
         r_wdata        <= 32'd0;
         r_rd           <= 5'd0;
         r_memtoreg     <= 1'b0;
         r_memwrite     <= 1'b0;
         r_regwrite     <= 1'b0;
         r_cnt          <= 8'd0;
         r_err          <= 1'b0;
         readdata_out   <= 32'd0;
         alu_result_out <= 32'd0;
         rd_out         <= 5'd0;
         memtoreg_out   <= 1'b0;
         regwrite_out   <= 1'b0;
         valid_out      <= 1'b0;
      end else begin
         r_err <= w_timeout;
         case (r_state)
            IDLE: begin
               if (w_mem_op) begin
                  r_addr       <= alu_result_in;
                  r_wdata      <= writedata_in;
                  r_rd         <= rd_in;
                  r_memtoreg   <= memtoreg_in;
                  r_memwrite   <= memwrite_in;
                  r_regwrite   <= regwrite_in;
                  r_cnt        <= 8'd0;
                  // The access result is written later; this slot is a bubble.
                  regwrite_out <= 1'b0;
                  valid_out    <= 1'b0;
               end else begin
                  alu_result_out <= alu_result_in;
                  rd_out         <= rd_in;
                  memtoreg_out   <= 1'b0;
                  regwrite_out   <= regwrite_in;
                  valid_out      <= 1'b1;
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  if (r_memtoreg) begin
                     readdata_out <= mem_rdata;
                  end
                  alu_result_out <= r_addr;
                  rd_out         <= r_rd;
                  memtoreg_out   <= r_memtoreg;
                  regwrite_out   <= r_regwrite;
                  valid_out      <= 1'b1;
               end else begin
                  if (!w_timeout) begin
                     r_cnt <= r_cnt + 8'd1;
                  end
                  regwrite_out <= 1'b0;
                  valid_out    <= 1'b0;
               end
            end
            default: begin
               valid_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage using a transaction-level
//               model of the MEM/WB results and memory handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] adder_in, alu_result_in, writedata_in;
   logic        zero_in, branch_in, memtoreg_in, memwrite_in, regwrite_in, addermuxselect_in;
   logic [4:0]  rd_in;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        pc_src_out;
   logic [31:0] branch_target_out;
   logic        stall_out, mem_err_out;
   logic [31:0] readdata_out, alu_result_out;
   logic [4:0]  rd_out;
   logic        memtoreg_out, regwrite_out, valid_out;

   always #5 clk = ~clk;

   mem_stage #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .adder_in(adder_in), .alu_result_in(alu_result_in), .writedata_in(writedata_in),
      .zero_in(zero_in), .branch_in(branch_in), .memtoreg_in(memtoreg_in),
      .memwrite_in(memwrite_in), .regwrite_in(regwrite_in),
      .addermuxselect_in(addermuxselect_in), .rd_in(rd_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .pc_src_out(pc_src_out), .branch_target_out(branch_target_out),
      .stall_out(stall_out), .mem_err_out(mem_err_out),
      .readdata_out(readdata_out), .alu_result_out(alu_result_out), .rd_out(rd_out),
      .memtoreg_out(memtoreg_out), .regwrite_out(regwrite_out), .valid_out(valid_out)
   );

   int tests = 0;
   int fails = 0;

   // Expected MEM/WB contents; k_* marks fields the rules pin down.
   logic [31:0] e_rdata, e_alu;
   logic [4:0]  e_rd;
   logic        e_mtr, e_rw, e_valid;
   bit          k_fields, k_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      e_rdata = 32'd0; e_alu = 32'd0; e_rd = 5'd0;
      e_mtr = 1'b0; e_rw = 1'b0; e_valid = 1'b0;
      k_fields = 1'b1; k_rdata = 1'b1;
   endtask

   task automatic check_wb(input string tag);
      chk({tag, ".valid"}, 32'(valid_out), 32'(e_valid));
      chk({tag, ".regwrite"}, 32'(regwrite_out), 32'(e_rw));
      if (k_fields) begin
         chk({tag, ".alu_out"}, alu_result_out, e_alu);
         chk({tag, ".rd_out"}, 32'(rd_out), 32'(e_rd));
         chk({tag, ".memtoreg"}, 32'(memtoreg_out), 32'(e_mtr));
      end
      if (k_rdata) chk({tag, ".readdata"}, readdata_out, e_rdata);
   endtask

   task automatic idle_inputs();
      adder_in = 32'd0; alu_result_in = 32'd0; writedata_in = 32'd0;
      zero_in = 1'b0; branch_in = 1'b0; memtoreg_in = 1'b0; memwrite_in = 1'b0;
      regwrite_in = 1'b0; addermuxselect_in = 1'b0; rd_in = 5'd0;
      mem_ack = 1'b0; mem_rdata = 32'd0;
   endtask

   task automatic scramble();
      adder_in = $urandom; alu_result_in = $urandom; writedata_in = $urandom;
      zero_in = 1'($urandom); branch_in = 1'($urandom); memtoreg_in = 1'($urandom);
      memwrite_in = 1'($urandom); regwrite_in = 1'($urandom);
      addermuxselect_in = 1'($urandom); rd_in = 5'($urandom);
   endtask

   // Non-memory op; mem_ack/mem_rdata are randomised to show IDLE ignores them.
   task automatic alu_op(input logic [31:0] addr, input logic [4:0] rd, input logic rw,
                         input logic br, input logic zero, input logic ams,
                         input logic [31:0] adder);
      alu_result_in = addr; rd_in = rd; regwrite_in = rw;
      memtoreg_in = 1'b0; memwrite_in = 1'b0;
      branch_in = br; zero_in = zero; addermuxselect_in = ams; adder_in = adder;
      writedata_in = $urandom; mem_ack = 1'($urandom); mem_rdata = $urandom;
      #1;
      chk("alu.stall", 32'(stall_out), 32'd0);
      chk("alu.req", 32'(mem_req), 32'd0);
      chk("alu.pc_src", 32'(pc_src_out), 32'(br & zero));
      chk("alu.target", branch_target_out, ams ? addr : adder);
      @(posedge clk); #1;
      e_alu = addr; e_rd = rd; e_mtr = 1'b0; e_rw = rw; e_valid = 1'b1; k_fields = 1'b1;
      check_wb("alu");
      chk("alu.err", 32'(mem_err_out), 32'd0);
   endtask

   // Memory op acked in WAIT cycle n_ack (1-based); n_ack > TO means no ack.
   task automatic mem_op(input bit ld, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic rw, input int n_ack,
                         input logic [31:0] rdata, input logic br, input logic zero);
      int  last;
      bit  acked;
      logic ams;
      logic [31:0] adder;
      ams = 1'($urandom); adder = $urandom;
      alu_result_in = addr; writedata_in = wdata; rd_in = rd; regwrite_in = rw;
      memtoreg_in = ld; memwrite_in = !ld; branch_in = br; zero_in = zero;
      addermuxselect_in = ams; adder_in = adder; mem_ack = 1'($urandom);
      #1;
      chk("mem.detect_stall", 32'(stall_out), 32'd1);
      chk("mem.detect_req", 32'(mem_req), 32'd0);
      chk("mem.detect_pc_src", 32'(pc_src_out), 32'(br & zero));
      chk("mem.detect_target", branch_target_out, ams ? addr : adder);
      @(posedge clk); #1;
      acked = (n_ack >= 1 && n_ack <= TO);
      last  = acked ? n_ack : TO;
      for (int k = 1; k <= last; k++) begin
         scramble();
         mem_ack   = (k == n_ack);
         mem_rdata = (k == n_ack) ? rdata : $urandom;
         #1;
         chk("wait.req", 32'(mem_req), 32'd1);
         chk("wait.we", 32'(mem_we), 32'(!ld));
         chk("wait.addr", mem_addr, addr);
         chk("wait.wdata", mem_wdata, wdata);
         chk("wait.stall", 32'(stall_out), 32'd1);
         chk("wait.pc_src", 32'(pc_src_out), 32'd0);
         chk("wait.err", 32'(mem_err_out), 32'd0);
         @(posedge clk); #1;
         if (k != n_ack) begin
            chk("bubble.valid", 32'(valid_out), 32'd0);
            chk("bubble.regwrite", 32'(regwrite_out), 32'd0);
         end
      end
      mem_ack = 1'b0;
      if (acked) begin
         if (ld) e_rdata = rdata;
         e_alu = addr; e_rd = rd; e_mtr = ld; e_rw = rw; e_valid = 1'b1; k_fields = 1'b1;
         check_wb("ack");
         chk("ack.err", 32'(mem_err_out), 32'd0);
         chk("ack.req", 32'(mem_req), 32'd0);
      end else begin
         e_valid = 1'b0; e_rw = 1'b0; k_fields = 1'b0; k_rdata = 1'b0;
         check_wb("timeout");
         chk("timeout.err", 32'(mem_err_out), 32'd1);
         chk("timeout.req", 32'(mem_req), 32'd0);
      end
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      model_reset();
      branch_in = 1'b1; zero_in = 1'b1; memtoreg_in = 1'b1; adder_in = 32'h1234;
      #3;
      chk("rst.stall", 32'(stall_out), 32'd0);
      chk("rst.pc_src", 32'(pc_src_out), 32'd0);
      chk("rst.req", 32'(mem_req), 32'd0);
      chk("rst.err", 32'(mem_err_out), 32'd0);
      chk("rst.target", branch_target_out, 32'd0);
      check_wb("rst");
      @(posedge clk); #1;
      reset = 1'b1;

      // Plain ALU op, then both branch-target selections
      alu_op(32'h10, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      alu_op(32'h77, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
      alu_op(32'h80, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40);

      // Load acked on third WAIT cycle, store acked immediately
      mem_op(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 3, 32'hDEADBEEF, 1'b0, 1'b0);
      alu_op(32'h44, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      mem_op(1'b0, 32'h20, 32'h55, 5'd0, 1'b0, 1, 32'h0, 1'b0, 1'b0);

      // Timeout, then ack coinciding with the timeout cycle
      mem_op(1'b1, 32'h200, 32'h0, 5'd4, 1'b1, TO + 5, 32'h0, 1'b0, 1'b0);
      alu_op(32'h11, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      mem_op(1'b1, 32'h204, 32'h0, 5'd6, 1'b1, TO, 32'hCAFEF00D, 1'b1, 1'b1);
      alu_op(32'h12, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      // Reset asserted in the second WAIT cycle
      alu_result_in = 32'h300; writedata_in = 32'h99; rd_in = 5'd10; regwrite_in = 1'b1;
      memtoreg_in = 1'b1; memwrite_in = 1'b0; branch_in = 1'b0; zero_in = 1'b0;
      @(posedge clk); #1;
      scramble(); mem_ack = 1'b0;
      @(posedge clk); #1;
      branch_in = 1'b1; zero_in = 1'b1; memtoreg_in = 1'b1;
      reset = 1'b0;
      model_reset();
      #1;
      chk("arst.req", 32'(mem_req), 32'd0);
      chk("arst.stall", 32'(stall_out), 32'd0);
      chk("arst.pc_src", 32'(pc_src_out), 32'd0);
      chk("arst.we", 32'(mem_we), 32'd0);
      chk("arst.addr", mem_addr, 32'd0);
      chk("arst.wdata", mem_wdata, 32'd0);
      chk("arst.target", branch_target_out, 32'd0);
      check_wb("arst");
      @(posedge clk); #1;
      chk("arst.err", 32'(mem_err_out), 32'd0);
      idle_inputs();
      reset = 1'b1;
      alu_op(32'h5A, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Randomised mix of ALU ops, loads and stores
      for (int i = 0; i < 40; i++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         if (kind == 0) begin
            alu_op($urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom);
         end else begin
            mem_op(kind == 1, $urandom, $urandom, 5'($urandom), 1'($urandom),
                   int'($urandom_range(1, TO + 2)), $urandom, 1'($urandom), 1'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, meaning: maximum number of WAIT cycles before an outstanding access is abandoned.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-low (0 = reset asserted); clears all state immediately, independent of clk.
REQ-004 adder_in, alu_result_in, writedata_in  in  32 each  branch-adder target, ALU result (data address), store data from EX/MEM.
REQ-005 zero_in, branch_in, memtoreg_in, memwrite_in, regwrite_in, addermuxselect_in  in  1 each  EX/MEM flags; memtoreg_in=1 marks a load.
REQ-006 rd_in  in  5  destination register.
REQ-007 mem_req, mem_we  out  1 each  data-memory request and write enable.
REQ-008 mem_addr, mem_wdata  out  32 each  access address and store data.
REQ-009 mem_rdata  in  32, mem_ack  in  1  read data and completion, both sampled on the same edge.
REQ-010 pc_src_out  out  1, branch_target_out  out  32  redirect request and target to fetch.
REQ-011 stall_out  out  1  freeze request to the hazard unit.
REQ-012 mem_err_out  out  1  one-cycle pulse when an access times out.
REQ-013 readdata_out, alu_result_out  out  32 each; rd_out  out  5; memtoreg_out, regwrite_out, valid_out  out  1 each  registered MEM/WB outputs.

Function
REQ-014 The FSM SHALL have two states: IDLE and WAIT.
REQ-015 In IDLE, memtoreg_in|memwrite_in SHALL latch alu_result_in, writedata_in, rd_in, memtoreg_in, memwrite_in, and regwrite_in into hold registers and transition to WAIT on the next edge.
REQ-016 In WAIT, mem_req SHALL be 1, mem_we SHALL be the held memwrite, and mem_addr and mem_wdata SHALL be the held values, stable until the acknowledging edge.
REQ-017 In IDLE, mem_req SHALL be 0.
REQ-018 stall_out SHALL be 1 combinationally in the IDLE cycle that detects an access and in every WAIT cycle, including the ack cycle; otherwise it SHALL be 0.
REQ-019 All inputs from EX/MEM SHALL be ignored in WAIT.
REQ-020 In IDLE with no memory op, the MEM/WB registers SHALL load alu_result_in, rd_in, memtoreg_in=0, regwrite_in, and valid_out=1 at the next edge (latency 1), with readdata_out holding its previous value.
REQ-021 In IDLE with branch_in=regwrite_in=0 and no memory op, valid_out SHALL still be 1 and regwrite_out SHALL be 0.
REQ-022 On a WAIT edge with mem_ack=1, MEM/WB SHALL load readdata_out=mem_rdata for a load (or unchanged for a store), the held address, rd, memtoreg, and regwrite, with valid_out=1, and the FSM SHALL go to IDLE.
REQ-023 On every WAIT edge without mem_ack, valid_out SHALL be 0 and regwrite_out SHALL be 0 (bubble).
REQ-024 An 8-bit counter SHALL clear on entry to WAIT and increment on each WAIT edge without ack.
REQ-025 When the counter equals MEM_TIMEOUT-1 and mem_ack=0, the FSM SHALL return to IDLE, pulse mem_err_out for exactly one cycle, and write a bubble.
REQ-026 When mem_ack=1 coincides with the timeout, the ack SHALL win and no error SHALL be raised.
REQ-027 mem_ack SHALL be ignored while in IDLE.
REQ-028 pc_src_out SHALL equal branch_in & zero_in in IDLE and 0 in WAIT, combinationally.
REQ-029 branch_target_out SHALL equal alu_result_in when addermuxselect_in=1 and adder_in otherwise.
REQ-030 A branch and a memory op in the same IDLE cycle SHALL both be honoured.

Reset
REQ-031 While reset=0, the FSM SHALL be in IDLE, the counter and every hold register and registered output SHALL be 0, and mem_req, stall_out, mem_err_out, and pc_src_out SHALL be 0.
REQ-032 Asserting reset during WAIT SHALL drop mem_req immediately, abandon the access, and raise no mem_err_out.
REQ-033 After reset release, the first edge SHALL behave as IDLE.

Verification
REQ-034 ALU op alu_result_in=0x10, rd_in=5, regwrite_in=1 -> next cycle alu_result_out=0x10, rd_out=5, regwrite_out=1, valid_out=1, stall_out=0.
REQ-035 Load at 0x100, mem_ack after 3 WAIT cycles with mem_rdata=0xDEADBEEF -> stall_out high 4 cycles, mem_addr=0x100 stable, then readdata_out=0xDEADBEEF, memtoreg_out=1, valid_out=1.
REQ-036 Store 0x55 to 0x20, immediate ack -> mem_we=1 and mem_wdata=0x55 for 1 cycle, regwrite_out=0, stall_out high 2 cycles.
REQ-037 Load with no ack and MEM_TIMEOUT=15 -> mem_req high 15 cycles, mem_err_out pulses once, valid_out=0, FSM returns to IDLE.
REQ-038 branch_in=1, zero_in=1, addermuxselect_in=0, adder_in=0x40 -> pc_src_out=1, branch_target_out=0x40 in the same cycle; repeating with addermuxselect_in=1 and alu_result_in=0x80 -> branch_target_out=0x80.
REQ-039 reset driven 0 on the second WAIT cycle -> mem_req=0 and stall_out=0 before the next edge, and all outputs are 0.
